// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates MEM byte requests and IF word fetches onto
// one byte-wide synchronous RAM port (one-cycle read latency).
module mem_ctrl #(
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req_i,
  input  logic              mem_r_w_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [7:0]        mem_wdata_i,
  output logic [7:0]        mem_rdata_o,
  output logic              mem_ack_o,
  input  logic              if_req_i,
  input  logic [31:0]       if_addr_i,
  input  logic              if_flush_i,
  output logic [31:0]       if_inst_o,
  output logic              if_ack_o,
  input  logic [7:0]        ram_din_i,
  output logic [7:0]        ram_dout_o,
  output logic [ADDR_W-1:0] ram_a_o,
  output logic              ram_wr_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_MRD1, S_MRD2, S_MWR,
    S_IF0, S_IF1, S_IF2, S_IF3, S_IF4, S_IF5,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [31:0]         byte_buf_q, byte_buf_d;
  logic [ADDR_W-1:0]   ram_a_q, ram_a_d;
  logic [7:0]          ram_dout_q, ram_dout_d;
  logic                ram_wr_q, ram_wr_d;
  logic [7:0]          mem_rdata_q, mem_rdata_d;
  logic                mem_ack_q, mem_ack_d;
  logic [31:0]         if_inst_q, if_inst_d;
  logic                if_ack_q, if_ack_d;

  // Address bits above the RAM width are deliberately ignored.
  generate
    if (ADDR_W < 32) begin : g_unused_hi
      logic unused_hi_s;
      assign unused_hi_s = ^{mem_addr_i[31:ADDR_W], if_addr_i[31:ADDR_W]};
    end
  endgenerate

  // Next-state and next-output logic for the whole controller.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    byte_buf_d  = byte_buf_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = 1'b0;
    mem_rdata_d = mem_rdata_q;
    mem_ack_d   = 1'b0;
    if_inst_d   = if_inst_q;
    if_ack_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (mem_req_i) begin
          ram_a_d = mem_addr_i[ADDR_W-1:0];
          if (mem_r_w_i) begin
            ram_dout_d = mem_wdata_i;
            ram_wr_d   = 1'b1;
            state_d    = S_MWR;
          end else begin
            state_d = S_MRD1;
          end
        end else if (if_req_i && !if_flush_i) begin
          // Pointer is ADDR_W wide: 32-bit wrap then truncation is the same thing.
          ram_a_d    = if_addr_i[ADDR_W-1:0];
          ptr_d      = if_addr_i[ADDR_W-1:0] + ADDR_W'(1);
          byte_buf_d = 32'h0000_0000;
          state_d    = S_IF0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MRD1: state_d = S_MRD2;
      S_MRD2: begin
        mem_rdata_d = ram_din_i;
        mem_ack_d   = 1'b1;
        state_d     = S_DONE;
      end
      S_MWR: begin
        mem_ack_d = 1'b1;
        state_d   = S_DONE;
      end
      S_IF0, S_IF1, S_IF2, S_IF3, S_IF4, S_IF5: begin
        if (if_flush_i) begin
          byte_buf_d = 32'h0000_0000;
          state_d    = S_IDLE;
        end else begin
          // Address issue runs two states ahead of byte capture.
          case (state_q)
            S_IF0: begin
              ram_a_d = ptr_q;
              ptr_d   = ptr_q + ADDR_W'(1);
              state_d = S_IF1;
            end
            S_IF1: begin
              ram_a_d          = ptr_q;
              ptr_d            = ptr_q + ADDR_W'(1);
              byte_buf_d[7:0]  = ram_din_i;
              state_d          = S_IF2;
            end
            S_IF2: begin
              ram_a_d          = ptr_q;
              byte_buf_d[15:8] = ram_din_i;
              state_d          = S_IF3;
            end
            S_IF3: begin
              byte_buf_d[23:16] = ram_din_i;
              state_d           = S_IF4;
            end
            S_IF4: begin
              byte_buf_d[31:24] = ram_din_i;
              state_d           = S_IF5;
            end
            S_IF5: begin
              if_inst_d = byte_buf_q;
              if_ack_d  = 1'b1;
              state_d   = S_DONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      byte_buf_q  <= 32'h0000_0000;
      ram_a_q     <= '0;
      ram_dout_q  <= 8'h00;
      ram_wr_q    <= 1'b0;
      mem_rdata_q <= 8'h00;
      mem_ack_q   <= 1'b0;
      if_inst_q   <= 32'h0000_0000;
      if_ack_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      byte_buf_q  <= byte_buf_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      mem_rdata_q <= mem_rdata_d;
      mem_ack_q   <= mem_ack_d;
      if_inst_q   <= if_inst_d;
      if_ack_q    <= if_ack_d;
    end
  end

  assign mem_rdata_o = mem_rdata_q;
  assign mem_ack_o   = mem_ack_q;
  assign if_inst_o   = if_inst_q;
  assign if_ack_o    = if_ack_q;
  assign ram_dout_o  = ram_dout_q;
  assign ram_a_o     = ram_a_q;
  assign ram_wr_o    = ram_wr_q;

endmodule
